// File: rtl/regs_pkg.sv
// rtl/regs_pkg.sv - shared constants for the MIPS general-purpose register file
package regs_pkg;

    // Default geometry of the MIPS general-purpose register file
    localparam int REGS_WIDTH = 32;
    localparam int REGS_DEPTH = 32;

endpackage

// File: rtl/register_oe.sv
// rtl/register_oe.sv - loadable output register with tri-state output enable
module register_oe
    import regs_pkg::*;
#(
    parameter int WIDTH = REGS_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] q;

    // Capture din on a load edge, otherwise hold; asynchronous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end
    end

    // Drive the shared bus only while enabled; no clock in this path
    assign out = enable ? q : {WIDTH{1'bz}};

endmodule

// File: rtl/register_file_oe.sv
// rtl/register_file_oe.sv - register file with one write port and two tri-state read ports
module register_file_oe
    import regs_pkg::*;
#(
    parameter int WIDTH      = REGS_WIDTH,
    parameter int DEPTH      = REGS_DEPTH,
    parameter bit ZERO_REG   = 1'b1,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  load_a,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    input  logic                  enable_a,
    output logic [WIDTH-1:0]      out_a,
    input  logic                  load_b,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    input  logic                  enable_b,
    output logic [WIDTH-1:0]      out_b
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             write_ok;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;

    // An address is readable/writable storage only if it is in range and not the hardwired zero entry
    function automatic logic is_storage(input logic [ADDR_WIDTH-1:0] addr);
        logic ok;
        ok = (32'(addr) < DEPTH);
        if (ZERO_REG && (addr == '0)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Read value with write-through bypass so a same-edge load sees the incoming data
    function automatic logic [WIDTH-1:0] read_value(input logic [ADDR_WIDTH-1:0] addr);
        logic [WIDTH-1:0] val;
        val = '0;
        if (is_storage(addr)) begin
            if (write && (waddr == addr)) begin
                val = wdata;
            end else begin
                val = mem[addr];
            end
        end
        return val;
    endfunction

    // Write decode: writes to the zero entry or past the last entry are dropped
    always_comb begin
        write_ok = 1'b0;
        if (write && is_storage(waddr)) begin
            write_ok = 1'b1;
        end
    end

    // Storage array; reset clears every entry regardless of clock
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Per-port read mux feeding the output registers
    always_comb begin
        rdata_a = read_value(raddr_a);
        rdata_b = read_value(raddr_b);
    end

    register_oe #(
        .WIDTH (WIDTH)
    ) u_port_a (
        .clock  (clock),
        .reset  (reset),
        .load   (load_a),
        .enable (enable_a),
        .din    (rdata_a),
        .out    (out_a)
    );

    register_oe #(
        .WIDTH (WIDTH)
    ) u_port_b (
        .clock  (clock),
        .reset  (reset),
        .load   (load_b),
        .enable (enable_b),
        .din    (rdata_b),
        .out    (out_b)
    );

endmodule

// File: tb/tb_register_file_oe.sv
// tb/tb_register_file_oe.sv - directed self-checking bench for register_file_oe
module tb_register_file_oe;

    logic       clock;
    logic       reset;
    logic       write;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       load_a;
    logic [2:0] raddr_a;
    logic       enable_a;
    logic       load_b;
    logic [2:0] raddr_b;
    logic       enable_b;

    // Bus nets are weakly pulled high: an undriven (Z) port reads back as 8'hFF
    tri1 [7:0] out_a;
    tri1 [7:0] out_b;

    localparam logic [7:0] BUS_IDLE = 8'hFF;

    int checks = 0;
    int errors = 0;

    register_file_oe #(
        .WIDTH    (8),
        .DEPTH    (6),
        .ZERO_REG (1'b1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .write    (write),
        .waddr    (waddr),
        .wdata    (wdata),
        .load_a   (load_a),
        .raddr_a  (raddr_a),
        .enable_a (enable_a),
        .out_a    (out_a),
        .load_b   (load_b),
        .raddr_b  (raddr_b),
        .enable_b (enable_b),
        .out_b    (out_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        write  = 1'b0;
        load_a = 1'b0;
        load_b = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        write    = 1'b0;
        waddr    = '0;
        wdata    = '0;
        load_a   = 1'b0;
        raddr_a  = '0;
        enable_a = 1'b1;
        load_b   = 1'b0;
        raddr_b  = '0;
        enable_b = 1'b1;

        // Reset held, outputs enabled then disabled
        #3;
        check("reset_out_a", out_a, 8'h00);
        check("reset_out_b", out_b, 8'h00);
        enable_a = 1'b0;
        #1;
        check("reset_out_a_z", out_a, BUS_IDLE);
        check("reset_out_b_en", out_b, 8'h00);
        enable_b = 1'b0;
        #1;
        check("reset_out_b_z", out_b, BUS_IDLE);
        @(negedge clock);
        reset = 1'b1;

        // Write A5 to entry 3, then load both ports from it
        cyc();
        write = 1'b1; waddr = 3'd3; wdata = 8'hA5;
        cyc();
        idle();
        load_a = 1'b1; raddr_a = 3'd3; enable_a = 1'b1;
        load_b = 1'b1; raddr_b = 3'd3; enable_b = 1'b1;
        cyc();
        idle();
        check("load_a_a5", out_a, 8'hA5);
        check("load_b_a5", out_b, 8'hA5);
        enable_a = 1'b0;
        #1;
        check("disable_a_z", out_a, BUS_IDLE);
        enable_a = 1'b1;

        // Zero register: same-edge write FF to 0 must not bypass
        write = 1'b1; waddr = 3'd0; wdata = 8'hFF;
        load_a = 1'b1; raddr_a = 3'd0;
        cyc();
        idle();
        check("zero_reg_a", out_a, 8'h00);
        // Out of range: write 77 to 7, load port B from 7 on the same edge
        write = 1'b1; waddr = 3'd7; wdata = 8'h77;
        load_b = 1'b1; raddr_b = 3'd7;
        cyc();
        idle();
        check("out_of_range_b", out_b, 8'h00);
        load_a = 1'b1; raddr_a = 3'd0;
        cyc();
        idle();
        check("zero_reg_after", out_a, 8'h00);

        // Bypass: entry 2 holds 11, same-edge write 3C and load both ports
        write = 1'b1; waddr = 3'd2; wdata = 8'h11;
        cyc();
        idle();
        load_a = 1'b1; raddr_a = 3'd2;
        cyc();
        idle();
        check("entry2_11", out_a, 8'h11);
        write = 1'b1; waddr = 3'd2; wdata = 8'h3C;
        load_a = 1'b1; raddr_a = 3'd2;
        load_b = 1'b1; raddr_b = 3'd2;
        cyc();
        idle();
        check("bypass_a", out_a, 8'h3C);
        check("bypass_b", out_b, 8'h3C);

        // Hold/independence: port A keeps A5 while entry 3 becomes 5A
        load_a = 1'b1; raddr_a = 3'd3;
        cyc();
        idle();
        check("reload_a_a5", out_a, 8'hA5);
        write = 1'b1; waddr = 3'd3; wdata = 8'h5A;
        cyc();
        idle();
        load_b = 1'b1; raddr_b = 3'd3;
        cyc();
        idle();
        check("hold_a", out_a, 8'hA5);
        check("indep_b_5a", out_b, 8'h5A);
        load_a = 1'b1; raddr_a = 3'd3;
        load_b = 1'b1; raddr_b = 3'd3;
        cyc();
        idle();
        check("same_addr_a", out_a, 8'h5A);
        check("same_addr_b", out_b, 8'h5A);

        // Fill entries 1..5 with nonzero values and read back a couple
        for (int i = 1; i <= 5; i++) begin
            write = 1'b1; waddr = 3'(i); wdata = 8'(8'h10 + i);
            cyc();
        end
        idle();
        load_a = 1'b1; raddr_a = 3'd5;
        load_b = 1'b1; raddr_b = 3'd1;
        cyc();
        idle();
        check("fill_5", out_a, 8'h15);
        check("fill_1", out_b, 8'h11);

        // Reset pulsed mid-cycle; a write/load attempted across an edge while held
        #2;
        reset = 1'b0;
        #1;
        check("midreset_a", out_a, 8'h00);
        check("midreset_b", out_b, 8'h00);
        write = 1'b1; waddr = 3'd4; wdata = 8'hEE;
        load_a = 1'b1; raddr_a = 3'd4;
        cyc();
        check("reset_blocks_load", out_a, 8'h00);
        idle();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            load_a = 1'b1; raddr_a = 3'(i);
            cyc();
            idle();
            check($sformatf("cleared_%0d", i), out_a, 8'h00);
        end
        // First edge after release is active
        write = 1'b1; waddr = 3'd5; wdata = 8'h42;
        load_b = 1'b1; raddr_b = 3'd5;
        cyc();
        idle();
        check("post_reset_write", out_b, 8'h42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
